// File: rtl/execute_writeback.sv
// -----------------------------------------------------------------------------
// execute_writeback
//   Execute stage sitting directly behind decode. Holds the 4x8-bit register
//   file, runs single-cycle ALU ops with writeback in the same clock, and
//   (optionally) a multi-cycle shift-add multiply that stalls upstream.
//
//   Build option: define EXECUTE_MUL_EN to implement MUL (opcode 9) and the
//   MUL_RUN state. Without it, opcode 9 is a NOP and oSTALL is tied to 0.
//
// Parameters
//   REG_RST_VAL  reset value of R0..R3
//   MUL_ITERS    cycles spent in MUL_RUN (1, 2, 4 or 8)
//
// Ports
//   iCLK, iRST            clock, asynchronous active-high reset
//   iEXE_OP               operation code
//   iIN1_IDX, iIN2_IDX    source register indices
//   iIMM_VAL              immediate operand
//   iDST_IDX              destination register index
//   iSRC2_IS_REG_OR_IMM   1 = src2 is immediate, 0 = src2 is R[iIN2_IDX]
//   oSTALL                upstream holds while high
//   oWB_EN/IDX/DATA       one-cycle writeback report
//   oFLAG_Z, oFLAG_C      zero and carry/borrow flags
//   oDBG_REGS             {R3,R2,R1,R0}
// -----------------------------------------------------------------------------
module execute_writeback #(
  parameter logic [7:0] REG_RST_VAL = 8'h00,
  parameter int         MUL_ITERS   = 8
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [3:0]  iEXE_OP,
  input  logic [1:0]  iIN1_IDX,
  input  logic [1:0]  iIN2_IDX,
  input  logic [7:0]  iIMM_VAL,
  input  logic [1:0]  iDST_IDX,
  input  logic        iSRC2_IS_REG_OR_IMM,
  output logic        oSTALL,
  output logic        oWB_EN,
  output logic [1:0]  oWB_IDX,
  output logic [7:0]  oWB_DATA,
  output logic        oFLAG_Z,
  output logic        oFLAG_C,
  output logic [31:0] oDBG_REGS
);

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MOV = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;

  logic [7:0] rf [4];
  logic [7:0] src1, src2;

  assign src1      = rf[iIN1_IDX];
  assign src2      = iSRC2_IS_REG_OR_IMM ? iIMM_VAL : rf[iIN2_IDX];
  assign oDBG_REGS = {rf[3], rf[2], rf[1], rf[0]};

  // ---- stage p0: combinational ALU on the current register file ----
  logic [7:0]  alu_res;
  logic        alu_c, alu_we, alu_fl;
  logic [15:0] shl_t, shr_t;

  // Shifting through a 16-bit window leaves the last bit shifted out at a
  // fixed position; a zero shift amount naturally leaves that bit at 0.
  assign shl_t = {8'h00, src1} << src2[2:0];
  assign shr_t = {src1, 8'h00} >> src2[2:0];

  always_comb begin
    alu_res = 8'h00;
    alu_c   = 1'b0;
    alu_we  = 1'b0;
    alu_fl  = 1'b0;
    case (iEXE_OP)
      OP_ADD: begin {alu_c, alu_res} = {1'b0, src1} + {1'b0, src2}; alu_we = 1'b1; alu_fl = 1'b1; end
      OP_SUB: begin {alu_c, alu_res} = {1'b0, src1} - {1'b0, src2}; alu_we = 1'b1; alu_fl = 1'b1; end
      OP_AND: begin alu_res = src1 & src2; alu_we = 1'b1; alu_fl = 1'b1; end
      OP_OR:  begin alu_res = src1 | src2; alu_we = 1'b1; alu_fl = 1'b1; end
      OP_XOR: begin alu_res = src1 ^ src2; alu_we = 1'b1; alu_fl = 1'b1; end
      OP_SHL: begin alu_res = shl_t[7:0];  alu_c = shl_t[8]; alu_we = 1'b1; alu_fl = 1'b1; end
      OP_SHR: begin alu_res = shr_t[15:8]; alu_c = shr_t[7]; alu_we = 1'b1; alu_fl = 1'b1; end
      OP_MOV: begin alu_res = src2; alu_we = 1'b1; end
      OP_CMP: begin {alu_c, alu_res} = {1'b0, src1} - {1'b0, src2}; alu_fl = 1'b1; end
      default: ;  // NOP, MUL (handled by the FSM) and reserved codes
    endcase
  end

  logic       alu_go;
  logic       commit_we, commit_fl, commit_c;
  logic [1:0] commit_idx;
  logic [7:0] commit_data;

`ifdef EXECUTE_MUL_EN
  // ---- stage p1: multi-cycle shift-add multiply ----
  typedef enum logic {S_IDLE, S_MUL_RUN} state_t;

  localparam int BITS = 8 / MUL_ITERS;

  state_t      state, state_nxt;
  logic        mul_start, mul_done, mul_last;
  logic [3:0]  mul_cnt;
  logic [15:0] mul_acc, mul_acc_nxt, mul_mcand;
  logic [7:0]  mul_mplier;
  logic [1:0]  mul_dst;

  // Multiplicand is pre-shifted and multiplier pre-consumed, so each cycle
  // always looks at the low BITS bits of the remaining multiplier.
  always_comb begin
    mul_acc_nxt = mul_acc;
    for (int i = 0; i < BITS; i++) begin
      if (mul_mplier[i]) mul_acc_nxt = mul_acc_nxt + (mul_mcand << i);
    end
  end

  assign mul_last = (mul_cnt == 4'(MUL_ITERS - 1));

  always_comb begin
    state_nxt = state;
    mul_start = 1'b0;
    mul_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (iEXE_OP == OP_MUL) begin
          state_nxt = S_MUL_RUN;
          mul_start = 1'b1;
        end
      end
      S_MUL_RUN: begin
        if (mul_last) begin
          state_nxt = S_IDLE;
          mul_done  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state      <= S_IDLE;
      mul_cnt    <= 4'd0;
      mul_acc    <= 16'h0000;
      mul_mcand  <= 16'h0000;
      mul_mplier <= 8'h00;
      mul_dst    <= 2'd0;
    end else begin
      state <= state_nxt;
      if (mul_start) begin
        mul_cnt    <= 4'd0;
        mul_acc    <= 16'h0000;
        mul_mcand  <= {8'h00, src1};
        mul_mplier <= src2;
        mul_dst    <= iDST_IDX;
      end else if (state == S_MUL_RUN) begin
        mul_cnt    <= mul_cnt + 4'd1;
        mul_acc    <= mul_acc_nxt;
        mul_mcand  <= mul_mcand << BITS;
        mul_mplier <= mul_mplier >> BITS;
      end
    end
  end

  // Decoded straight from the state flop, so reset drops it without a clock.
  assign oSTALL = (state == S_MUL_RUN);
  assign alu_go = (state == S_IDLE) && !mul_start;

  always_comb begin
    commit_we   = alu_go & alu_we;
    commit_fl   = alu_go & alu_fl;
    commit_idx  = iDST_IDX;
    commit_data = alu_res;
    commit_c    = alu_c;
    if (mul_done) begin
      commit_we   = 1'b1;
      commit_fl   = 1'b1;
      commit_idx  = mul_dst;
      commit_data = mul_acc_nxt[7:0];
      commit_c    = |mul_acc_nxt[15:8];
    end
  end
`else
  logic unused_mul_iters;
  assign unused_mul_iters = (MUL_ITERS != 0);
  assign oSTALL = 1'b0;
  assign alu_go = 1'b1;

  always_comb begin
    commit_we   = alu_go & alu_we;
    commit_fl   = alu_go & alu_fl;
    commit_idx  = iDST_IDX;
    commit_data = alu_res;
    commit_c    = alu_c;
  end
`endif

  // ---- stage p2: register file, writeback report and flags ----
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int i = 0; i < 4; i++) rf[i] <= REG_RST_VAL;
      oWB_EN   <= 1'b0;
      oWB_IDX  <= 2'd0;
      oWB_DATA <= 8'h00;
      oFLAG_Z  <= 1'b0;
      oFLAG_C  <= 1'b0;
    end else begin
      oWB_EN <= commit_we;
      if (commit_we) begin
        rf[commit_idx] <= commit_data;
        oWB_IDX        <= commit_idx;
        oWB_DATA       <= commit_data;
      end
      if (commit_fl) begin
        oFLAG_Z <= (commit_data == 8'h00);
        oFLAG_C <= commit_c;
      end
    end
  end

endmodule
